// File: rtl/adc_capture_pkg.sv
// Shared constants for the ADC frame-capture buffer: register map, bit indices, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_capture_pkg;

    // Word addresses decoded from BUS_ADDR[3:0]
    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_LEN    = 4'd2;
    localparam logic [3:0] ADDR_DATA   = 4'd3;
    localparam logic [3:0] ADDR_ID     = 4'd4;
    localparam logic [3:0] ADDR_THRESH = 4'd5;

    // CTRL bits: arm and clear are write pulses, irq_en is sticky
    localparam int CTRL_ARM    = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bits; the captured-word count occupies [31:16]
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_CNT_LSB = 16;

    localparam int SMP_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } cap_state_e;

    // One RAM word per sample pair: B in the upper half, A in the lower half,
    // each half carrying its overrange flag in the top bit.
    function automatic logic [31:0] pack_sample(input logic [SMP_W-1:0] a,
                                                input logic [SMP_W-1:0] b,
                                                input logic             ofa,
                                                input logic             ofb);
        return {ofb, 1'b0, b, ofa, 1'b0, a};
    endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port RAM, 2^AW x DW: one synchronous write port, one registered read port.
// Latency: read data appears one cycle after rd_addr; write lands at the clock edge.
// Backpressure: none; both ports accept an access every cycle.
module adc_capture_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_dat_d;
    logic [DW-1:0] rd_dat_q;

    // Storage array: written on the edge, no reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Asynchronous read of the array feeding the output register
    always_comb begin
        rd_dat_d = mem[rd_addr];
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/adc_capture_buf.sv
// ADC frame-capture buffer: stores a programmable-length frame of packed A/B sample pairs, MCU drains via DATA.
// Latency: BUS_DATA_RD one cycle after BUS_RD; irq one cycle after done; ADC word lands in RAM on its ad_valid edge.
// Backpressure: none; ADC samples outside CAPTURE are dropped, DATA pops need >=2 idle cycles between strobes.
// Optional level trigger is compiled in with `define ADC_CAPTURE_TRIG_EN.
module adc_capture_buf
    import adc_capture_pkg::*;
#(
    parameter int          AW       = 10,
    parameter logic [31:0] ID_VALUE = 32'h0000_5A5A
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [31:0] BUS_ADDR,
    input  logic        BUS_WR,
    input  logic        BUS_RD,
    input  logic [31:0] BUS_DATA_WR,
    output logic [31:0] BUS_DATA_RD,
    input  logic [13:0] ad_a_data,
    input  logic [13:0] ad_b_data,
    input  logic        ad_valid,
    input  logic        ad_ofa,
    input  logic        ad_ofb,
    output logic        irq
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    cap_state_e  state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [AW:0] len_eff_q, len_eff_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] avail_q, avail_d;
    logic        irq_q, irq_d;
    logic [31:0] bus_rd_dat_q, bus_rd_dat_d;

`ifdef ADC_CAPTURE_TRIG_EN
    logic [SMP_W-1:0] thresh_q, thresh_d;
    logic [SMP_W-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
`endif

    logic [3:0]  addr;
    logic        wr_ctrl;
    logic        wr_len;
    logic        arm;
    logic        clr;
    logic        busy;
    logic        pop;
    logic        word_avail;
    logic        store;
    logic        ram_we;
    logic [31:0] ram_wr_dat;
    logic [31:0] ram_rd_dat;
    logic [AW:0] wr_ptr_inc;
    logic [AW:0] len_eff_new;
    logic [31:0] status_w;
    logic        unused_addr_hi;

    assign addr           = BUS_ADDR[3:0];
    assign unused_addr_hi = ^BUS_ADDR[31:4];
    assign wr_ctrl        = BUS_WR && (addr == ADDR_CTRL);
    assign wr_len         = BUS_WR && (addr == ADDR_LEN);
    assign arm            = wr_ctrl && BUS_DATA_WR[CTRL_ARM];
    assign clr            = wr_ctrl && BUS_DATA_WR[CTRL_CLEAR];
    assign busy           = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
    assign pop            = BUS_RD && (addr == ADDR_DATA);
    // avail_q trails wr_ptr_q by a cycle so a word is only popped once the
    // registered RAM read port has had time to see it
    assign word_avail     = (rd_ptr_q != avail_q);
    assign wr_ptr_inc     = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    assign ram_wr_dat     = pack_sample(ad_a_data, ad_b_data, ad_ofa, ad_ofb);
    // Zero or oversized lengths mean a full buffer
    assign len_eff_new    = ((len_q == 32'd0) || (len_q > DEPTH_W)) ? DEPTH_W[AW:0] : len_q[AW:0];

    // Capture FSM next state plus register-file, pointer and flag updates
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        len_eff_d = len_eff_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_we    = 1'b0;
        store     = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
        thresh_d   = thresh_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (BUS_WR && (addr == ADDR_THRESH)) begin
            thresh_d = BUS_DATA_WR[SMP_W-1:0];
        end
`endif
        // LEN is only sampled into len_eff on arm, so mid-capture writes wait
        if (wr_len) begin
            len_d = BUS_DATA_WR;
        end
        if (wr_ctrl) begin
            irq_en_d = BUS_DATA_WR[CTRL_IRQ_EN];
        end
        if (pop && word_avail) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d   = ST_WAIT_TRIG;
                    done_d    = 1'b0;
                    ovr_d     = 1'b0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    len_eff_d = len_eff_new;
`ifdef ADC_CAPTURE_TRIG_EN
                    prev_vld_d = 1'b0;
`endif
                end
            end
            ST_WAIT_TRIG: begin
`ifdef ADC_CAPTURE_TRIG_EN
                // Rising crossing of THRESH on channel A; the crossing sample is stored
                if (ad_valid) begin
                    prev_d     = ad_a_data;
                    prev_vld_d = 1'b1;
                    if (prev_vld_q && (prev_q < thresh_q) && (ad_a_data >= thresh_q)) begin
                        store = 1'b1;
                    end
                end
`else
                state_d = ST_CAPTURE;
`endif
            end
            ST_CAPTURE: begin
                store = ad_valid;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (store) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            if (ad_ofa || ad_ofb) begin
                ovr_d = 1'b1;
            end
            if (wr_ptr_inc == len_eff_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_CAPTURE;
            end
        end

        // Clear overrides everything, including a simultaneous arm or sample
        if (clr) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            ovr_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ram_we   = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
            prev_vld_d = 1'b0;
`endif
        end

        avail_d = (wr_ptr_d == '0) ? '0 : wr_ptr_q;
        irq_d   = done_d & irq_en_d;
    end

    // STATUS word assembly
    always_comb begin
        status_w                       = '0;
        status_w[STAT_BUSY]            = busy;
        status_w[STAT_DONE]            = done_q;
        status_w[STAT_OVR]             = ovr_q;
        status_w[31:STAT_CNT_LSB]      = 16'(wr_ptr_q);
    end

    // Bus read mux; the result is held until the next BUS_RD
    always_comb begin
        bus_rd_dat_d = bus_rd_dat_q;
        if (BUS_RD) begin
            case (addr)
                ADDR_CTRL: begin
                    bus_rd_dat_d              = '0;
                    bus_rd_dat_d[CTRL_IRQ_EN] = irq_en_q;
                end
                ADDR_STATUS: bus_rd_dat_d = status_w;
                ADDR_LEN:    bus_rd_dat_d = len_q;
                ADDR_DATA:   bus_rd_dat_d = word_avail ? ram_rd_dat : 32'd0;
                ADDR_ID:     bus_rd_dat_d = ID_VALUE;
`ifdef ADC_CAPTURE_TRIG_EN
                ADDR_THRESH: bus_rd_dat_d = {{(32-SMP_W){1'b0}}, thresh_q};
`endif
                default:     bus_rd_dat_d = '0;
            endcase
        end
    end

    // Control, pointer and bus-side state registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            len_eff_q    <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            avail_q      <= '0;
            irq_q        <= 1'b0;
            bus_rd_dat_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            len_eff_q    <= len_eff_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            avail_q      <= avail_d;
            irq_q        <= irq_d;
            bus_rd_dat_q <= bus_rd_dat_d;
        end
    end

`ifdef ADC_CAPTURE_TRIG_EN
    // Trigger threshold and previous channel-A sample
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q   <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            thresh_q   <= thresh_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`endif

    adc_capture_ram #(
        .AW (AW),
        .DW (32)
    ) u_ram (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_dat  (ram_wr_dat),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_dat  (ram_rd_dat)
    );

    assign BUS_DATA_RD = bus_rd_dat_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_adc_capture_buf.sv
// Directed bench for adc_capture_buf: register map, frame capture, drain, overrange, clear/arm, trigger.
// Latency: reads sampled one cycle after the BUS_RD strobe.
// Backpressure: DATA pops spaced three cycles apart.
module tb_adc_capture_buf;
    import adc_capture_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [31:0] BUS_ADDR;
    logic        BUS_WR;
    logic        BUS_RD;
    logic [31:0] BUS_DATA_WR;
    logic [31:0] BUS_DATA_RD;
    logic [13:0] ad_a_data;
    logic [13:0] ad_b_data;
    logic        ad_valid;
    logic        ad_ofa;
    logic        ad_ofb;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    adc_capture_buf #(.AW(AW), .ID_VALUE(32'h0000_5A5A)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .BUS_ADDR    (BUS_ADDR),
        .BUS_WR      (BUS_WR),
        .BUS_RD      (BUS_RD),
        .BUS_DATA_WR (BUS_DATA_WR),
        .BUS_DATA_RD (BUS_DATA_RD),
        .ad_a_data   (ad_a_data),
        .ad_b_data   (ad_b_data),
        .ad_valid    (ad_valid),
        .ad_ofa      (ad_ofa),
        .ad_ofb      (ad_ofb),
        .irq         (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        BUS_ADDR = {28'd0, a}; BUS_DATA_WR = d; BUS_WR = 1'b1;
        @(negedge sys_clk);
        BUS_WR = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge sys_clk);
        BUS_ADDR = {28'd0, a}; BUS_RD = 1'b1;
        @(negedge sys_clk);
        BUS_RD = 1'b0;
        d = BUS_DATA_RD;
        @(negedge sys_clk);
    endtask

    task automatic send_sample(input logic [13:0] a, input logic [13:0] b,
                               input logic ofa, input logic ofb);
        @(negedge sys_clk);
        ad_a_data = a; ad_b_data = b; ad_ofa = ofa; ad_ofb = ofb; ad_valid = 1'b1;
        @(negedge sys_clk);
        ad_valid = 1'b0;
    endtask

    // Arm and let WAIT_TRIG pass; with the trigger built in, a zero primer
    // sample lets the next sample with A >= 1 cross THRESH=1.
    task automatic start_capture(input logic [31:0] ctrl);
        bus_write(ADDR_CTRL, ctrl);
        repeat (2) @(negedge sys_clk);
`ifdef ADC_CAPTURE_TRIG_EN
        send_sample(14'd0, 14'd0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0;
        BUS_ADDR = '0; BUS_WR = 1'b0; BUS_RD = 1'b0; BUS_DATA_WR = '0;
        ad_a_data = '0; ad_b_data = '0; ad_valid = 1'b0; ad_ofa = 1'b0; ad_ofb = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (BUS_DATA_RD !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: rd=%h irq=%b, expected 0/0", BUS_DATA_RD, irq);
        end
        rst_n = 1'b1;
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
        bus_read(ADDR_ID, d);
        n_checks++;
        if (d !== 32'h0000_5A5A) begin n_fail++; $display("FAIL id: got %h expected 00005a5a", d); end
        bus_read(4'd7, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_rd: got %h expected 0", d); end
        bus_write(ADDR_THRESH, 32'd1);
        bus_read(ADDR_THRESH, d);
        n_checks++;
`ifdef ADC_CAPTURE_TRIG_EN
        if (d !== 32'd1) begin n_fail++; $display("FAIL thresh_rd: got %h expected 1", d); end
`else
        if (d !== 32'd0) begin n_fail++; $display("FAIL thresh_rd: got %h expected 0", d); end
`endif
    endtask

    task automatic test_basic_frame;
        logic [31:0] d;
        logic [31:0] exp;
        bus_write(ADDR_LEN, 32'd4);
        start_capture(32'd5);
        for (int i = 0; i < 4; i++) send_sample(14'(i + 1), 14'(32'h1000 + i), 1'b0, 1'b0);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0004_0002) begin n_fail++; $display("FAIL frame_status: got %h expected 00040002", d); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL frame_irq: got %b expected 1", irq); end
        for (int i = 0; i < 5; i++) begin
            exp = (i < 4) ? (32'h1000_0001 + 32'h0001_0001 * i) : 32'd0;
            bus_read(ADDR_DATA, d);
            n_checks++;
            if (d !== exp) begin n_fail++; $display("FAIL frame_data[%0d]: got %h expected %h", i, d, exp); end
        end
    endtask

    task automatic test_full_depth;
        logic [31:0] d;
        logic [31:0] exp;
        bus_write(ADDR_LEN, 32'd0);
        start_capture(32'd1);
        for (int i = 0; i < DEPTH; i++) send_sample(14'(i + 1), 14'(i + 5), 1'b0, 1'b0);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0400_0002) begin n_fail++; $display("FAIL depth_status: got %h expected 04000002", d); end
        send_sample(14'h3FFF, 14'h3FFF, 1'b1, 1'b1);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0400_0002) begin n_fail++; $display("FAIL depth_extra: got %h expected 04000002", d); end
        bus_read(ADDR_LEN, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL len_rd: got %h expected 0", d); end
        for (int i = 0; i <= DEPTH; i++) begin
            exp = (i < DEPTH) ? {2'b00, 14'(i + 5), 2'b00, 14'(i + 1)} : 32'd0;
            bus_read(ADDR_DATA, d);
            n_checks++;
            if (d !== exp) begin n_fail++; $display("FAIL depth_data[%0d]: got %h expected %h", i, d, exp); end
        end
    endtask

    task automatic test_overrange_clear;
        logic [31:0] d;
        bus_write(ADDR_LEN, 32'd3);
        start_capture(32'd1);
        send_sample(14'h0010, 14'h0020, 1'b0, 1'b0);
        send_sample(14'h0011, 14'h0021, 1'b0, 1'b1);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0002_0005) begin n_fail++; $display("FAIL ovr_status: got %h expected 00020005", d); end
        bus_read(ADDR_DATA, d);
        n_checks++;
        if (d !== 32'h0020_0010) begin n_fail++; $display("FAIL ovr_word0: got %h expected 00200010", d); end
        bus_read(ADDR_DATA, d);
        n_checks++;
        if (d !== 32'h8021_0011) begin n_fail++; $display("FAIL ovr_word1: got %h expected 80210011", d); end
        bus_read(ADDR_DATA, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL ovr_empty: got %h expected 0", d); end
        bus_write(ADDR_CTRL, 32'd2);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL clear_status: got %h irq=%b expected 0/0", d, irq);
        end
    endtask

    task automatic test_arm_clear_priority;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'd3);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'd0 || dut.state_q !== ST_IDLE) begin
            n_fail++; $display("FAIL arm_clear: status=%h state=%0d expected 0/IDLE", d, dut.state_q);
        end
        bus_write(ADDR_LEN, 32'd8);
        start_capture(32'd1);
        for (int i = 0; i < 3; i++) send_sample(14'(32'h21 + i), 14'h0001, 1'b0, 1'b0);
        bus_write(ADDR_CTRL, 32'd1);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0003_0001) begin n_fail++; $display("FAIL arm_busy: got %h expected 00030001", d); end
        send_sample(14'h0024, 14'h0001, 1'b0, 1'b0);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0004_0001) begin n_fail++; $display("FAIL arm_busy_cont: got %h expected 00040001", d); end
        bus_write(ADDR_CTRL, 32'd2);
    endtask

    task automatic test_rearm_len_irq;
        logic [31:0] d;
        bus_write(ADDR_LEN, 32'd2);
        start_capture(32'd5);
        send_sample(14'h0031, 14'h0002, 1'b0, 1'b0);
        bus_write(ADDR_LEN, 32'd3);
        send_sample(14'h0032, 14'h0002, 1'b0, 1'b0);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0002_0002 || irq !== 1'b1) begin
            n_fail++; $display("FAIL len_midcap: status=%h irq=%b expected 00020002/1", d, irq);
        end
        bus_read(ADDR_LEN, d);
        n_checks++;
        if (d !== 32'd3) begin n_fail++; $display("FAIL len_readback: got %h expected 3", d); end
        bus_write(ADDR_CTRL, 32'd0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_en_off: got %b expected 0", irq); end
        start_capture(32'd1);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL rearm_done: got %h expected 00000001", d); end
        for (int i = 0; i < 3; i++) send_sample(14'(32'h40 + i), 14'h0003, 1'b0, 1'b0);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0003_0002 || irq !== 1'b0) begin
            n_fail++; $display("FAIL rearm_len3: status=%h irq=%b expected 00030002/0", d, irq);
        end
    endtask

    task automatic test_reset_mid_capture;
        logic [31:0] d;
        bus_write(ADDR_LEN, 32'd4);
        start_capture(32'd5);
        send_sample(14'h0007, 14'h0001, 1'b0, 1'b0);
        send_sample(14'h0008, 14'h0001, 1'b0, 1'b0);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0002_0001) begin n_fail++; $display("FAIL midcap_status: got %h expected 00020001", d); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (BUS_DATA_RD !== 32'd0 || irq !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: rd=%h irq=%b state=%0d expected 0/0/IDLE", BUS_DATA_RD, irq, dut.state_q);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL post_reset_status: got %h expected 0", d); end
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_trigger;
        logic [31:0] d;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp_th;
        bus_write(ADDR_LEN, 32'd2);
        bus_write(ADDR_THRESH, 32'h2000);
        bus_write(ADDR_CTRL, 32'd1);
        repeat (2) @(negedge sys_clk);
        send_sample(14'h1000, 14'h0100, 1'b0, 1'b0);
        send_sample(14'h1FFF, 14'h0100, 1'b0, 1'b0);
        send_sample(14'h2000, 14'h0100, 1'b0, 1'b0);
        send_sample(14'h2100, 14'h0100, 1'b0, 1'b0);
`ifdef ADC_CAPTURE_TRIG_EN
        exp0 = 32'h0100_2000; exp1 = 32'h0100_2100; exp_th = 32'h2000;
`else
        exp0 = 32'h0100_1000; exp1 = 32'h0100_1FFF; exp_th = 32'd0;
`endif
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0002_0002) begin n_fail++; $display("FAIL trig_status: got %h expected 00020002", d); end
        bus_read(ADDR_THRESH, d);
        n_checks++;
        if (d !== exp_th) begin n_fail++; $display("FAIL trig_thresh: got %h expected %h", d, exp_th); end
        bus_read(ADDR_DATA, d);
        n_checks++;
        if (d !== exp0) begin n_fail++; $display("FAIL trig_word0: got %h expected %h", d, exp0); end
        bus_read(ADDR_DATA, d);
        n_checks++;
        if (d !== exp1) begin n_fail++; $display("FAIL trig_word1: got %h expected %h", d, exp1); end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_full_depth;
        test_overrange_clear;
        test_arm_clear_priority;
        test_rearm_len_irq;
        test_reset_mid_capture;
        test_trigger;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
